// File: rtl/fft_ctrl_pkg.sv
// Shared encodings for the FFT control slice: butterfly variants, scheduler
// states and the 24-bit unified data word layout.
package fft_ctrl_pkg;

  localparam logic [1:0] BF_FP8       = 2'b00;
  localparam logic [1:0] BF_FP4       = 2'b01;
  localparam logic [1:0] BF_8ADD_4MUL = 2'b10;
  localparam logic [1:0] BF_4ADD_8MUL = 2'b11;

  localparam int unsigned STAGE_W = 4;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned DRAIN_W = 2;

  localparam int unsigned WORD_W = 24;
  localparam int unsigned RE_LSB = 0;
  localparam int unsigned RE_W   = 12;
  localparam int unsigned IM_LSB = 12;
  localparam int unsigned IM_W   = 12;

  typedef struct packed {
    logic [IM_W-1:0] im;
    logic [RE_W-1:0] re;
  } cplx_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational radix-2 DIT address generator: (stage, k) -> A/B operand
// addresses and the twiddle ROM index for that butterfly.
module fft_bfly_addr_gen
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned LOG2N = 5
) (
  input  logic [STAGE_W-1:0] stage,
  input  logic [LOG2N-2:0]   k,
  output logic [LOG2N-1:0]   addr_a_c,
  output logic [LOG2N-1:0]   addr_b_c,
  output logic [LOG2N-2:0]   tw_addr_c
);

  localparam int unsigned AW = LOG2N;
  localparam int unsigned TW = LOG2N - 1;

  logic [AW-1:0]      k_ext;
  logic [AW-1:0]      half;
  logic [AW-1:0]      low;
  logic [AW-1:0]      high;
  logic [STAGE_W-1:0] tw_sh;

  // Group index goes above the span bit; position within the group below it.
  always_comb begin
    k_ext     = AW'(k);
    half      = AW'(1) << stage;
    low       = k_ext & (half - AW'(1));
    high      = (k_ext >> stage) << (stage + STAGE_W'(1));
    addr_a_c  = high | low;
    addr_b_c  = addr_a_c | half;
    tw_sh     = STAGE_W'(TW) - stage;
    tw_addr_c = TW'(low) << tw_sh;
  end

endmodule

// File: rtl/fft_butterfly_scheduler.sv
// Sequences one in-place radix-2 DIT FFT: issues butterfly reads stage by
// stage and replays them as write-backs after the fixed read latency.
module fft_butterfly_scheduler
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned LOG2N  = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2*LOG2N-1:0]   mode_cfg,
  output logic                 rd_en,
  output logic [LOG2N-1:0]     rd_addr_a,
  output logic [LOG2N-1:0]     rd_addr_b,
  output logic [LOG2N-2:0]     tw_addr,
  output logic                 wr_en,
  output logic [LOG2N-1:0]     wr_addr_a,
  output logic [LOG2N-1:0]     wr_addr_b,
  output logic [1:0]           bfly_mode,
  output logic [STAGE_W-1:0]   stage_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned AW    = LOG2N;
  localparam int unsigned KW    = LOG2N - 1;
  localparam int unsigned CFG_W = 2 * LOG2N;

  localparam logic [KW-1:0]      K_LAST     = '1;
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(LOG2N - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT - 1);

  fsm_state_e         state, state_n;
  logic [KW-1:0]      k, k_n;
  logic [STAGE_W-1:0] stage_n;
  logic [DRAIN_W-1:0] drain, drain_n;
  logic [CFG_W-1:0]   mode_q, mode_n;
  logic               abort_act_c;

  logic               rd_en_d, busy_d, done_d;
  logic [MODE_W-1:0]  rd_mode, rd_mode_d;
  logic [AW-1:0]      addr_a_c, addr_b_c;
  logic [KW-1:0]      tw_c;

  logic               pv [RD_LAT];
  logic [AW-1:0]      pa [RD_LAT];
  logic [AW-1:0]      pb [RD_LAT];
  logic [MODE_W-1:0]  pm [RD_LAT];

  assign abort_act_c = abort && (state != ST_IDLE);

  fft_bfly_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .stage     (stage_n),
    .k         (k_n),
    .addr_a_c  (addr_a_c),
    .addr_b_c  (addr_b_c),
    .tw_addr_c (tw_c)
  );

  // State, counters and registered issue-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      k         <= '0;
      drain     <= '0;
      mode_q    <= '0;
      stage_idx <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      rd_mode   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      drain     <= drain_n;
      mode_q    <= mode_n;
      stage_idx <= stage_n;
      rd_en     <= rd_en_d;
      rd_addr_a <= addr_a_c;
      rd_addr_b <= addr_b_c;
      tw_addr   <= tw_c;
      rd_mode   <= rd_mode_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    stage_n = stage_idx;
    drain_n = drain;
    mode_n  = mode_q;
    unique case (state)
      ST_IDLE: begin
        stage_n = '0;
        k_n     = '0;
        if (start && !abort) begin
          mode_n  = mode_cfg;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (k == K_LAST) begin
          drain_n = '0;
          state_n = ST_DRAIN;
        end else begin
          k_n = k + KW'(1);
        end
      end
      ST_DRAIN: begin
        // Next stage waits until every write of this stage has landed.
        if (drain == DRAIN_LAST) begin
          if (stage_idx == STAGE_LAST) begin
            state_n = ST_DONE;
          end else begin
            stage_n = stage_idx + STAGE_W'(1);
            k_n     = '0;
            state_n = ST_ISSUE;
          end
        end else begin
          drain_n = drain + DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        stage_n = '0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort_act_c) begin
      state_n = ST_IDLE;
      stage_n = '0;
      k_n     = '0;
    end
  end

  always_comb begin
    rd_en_d   = (state_n == ST_ISSUE);
    busy_d    = (state_n != ST_IDLE);
    done_d    = (state_n == ST_DONE);
    rd_mode_d = MODE_W'(mode_n >> {stage_n, 1'b0});
  end

  // Write-back delay line; abort drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
        pb[i] <= '0;
        pm[i] <= '0;
      end
    end else begin
      pv[0] <= rd_en && !abort_act_c;
      pa[0] <= rd_addr_a;
      pb[0] <= rd_addr_b;
      if (rd_en && !abort_act_c) pm[0] <= rd_mode;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1] && !abort_act_c;
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
        if (pv[i-1] && !abort_act_c) pm[i] <= pm[i-1];
      end
    end
  end

  assign wr_en     = pv[RD_LAT-1];
  assign wr_addr_a = pa[RD_LAT-1];
  assign wr_addr_b = pb[RD_LAT-1];
  assign bfly_mode = pm[RD_LAT-1];

endmodule

// File: tb/tb_fft_butterfly_scheduler.sv
// Randomized bench for fft_butterfly_scheduler: two instances (defaults and
// LOG2N=3/RD_LAT=3) checked cycle by cycle against a schedule model.
module tb_fft_butterfly_scheduler;

  localparam int unsigned L1 = 5;
  localparam int unsigned R1 = 1;
  localparam int unsigned L2 = 3;
  localparam int unsigned R2 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            start1, abort1, rd_en1, wr_en1, busy1, done1;
  logic [2*L1-1:0] cfg1;
  logic [L1-1:0]   rd_addr_a1, rd_addr_b1, wr_addr_a1, wr_addr_b1;
  logic [L1-2:0]   tw_addr1;
  logic [1:0]      bfly_mode1;
  logic [3:0]      stage_idx1;

  logic            start2, abort2, rd_en2, wr_en2, busy2, done2;
  logic [2*L2-1:0] cfg2;
  logic [L2-1:0]   rd_addr_a2, rd_addr_b2, wr_addr_a2, wr_addr_b2;
  logic [L2-2:0]   tw_addr2;
  logic [1:0]      bfly_mode2;
  logic [3:0]      stage_idx2;

  fft_butterfly_scheduler #(.LOG2N(L1), .RD_LAT(R1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .mode_cfg(cfg1),
    .rd_en(rd_en1), .rd_addr_a(rd_addr_a1), .rd_addr_b(rd_addr_b1), .tw_addr(tw_addr1),
    .wr_en(wr_en1), .wr_addr_a(wr_addr_a1), .wr_addr_b(wr_addr_b1), .bfly_mode(bfly_mode1),
    .stage_idx(stage_idx1), .busy(busy1), .done(done1)
  );

  fft_butterfly_scheduler #(.LOG2N(L2), .RD_LAT(R2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .mode_cfg(cfg2),
    .rd_en(rd_en2), .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2), .tw_addr(tw_addr2),
    .wr_en(wr_en2), .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2), .bfly_mode(bfly_mode2),
    .stage_idx(stage_idx2), .busy(busy2), .done(done2)
  );

  int checks = 0;
  int errors = 0;
  int cur_mode [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Address fields are compared only while their strobe is high unless raw.
  function automatic logic [63:0] pk(input bit raw, input bit rd, input int a, input int b,
                                     input int tw, input bit wr, input int wa, input int wb,
                                     input int md, input int st, input bit bs, input bit dn);
    logic [9:0] ra, rb, rt, xa, xb;
    ra = '0; rb = '0; rt = '0; xa = '0; xb = '0;
    if (raw || rd) begin ra = 10'(a); rb = 10'(b); rt = 10'(tw); end
    if (raw || wr) begin xa = 10'(wa); xb = 10'(wb); end
    return {4'd0, rd, ra, rb, rt, wr, xa, xb, 2'(md), 4'(st), bs, dn};
  endfunction

  function automatic logic [63:0] obs(input int sel, input bit raw);
    if (sel == 0)
      return pk(raw, rd_en1, int'(rd_addr_a1), int'(rd_addr_b1), int'(tw_addr1), wr_en1,
                int'(wr_addr_a1), int'(wr_addr_b1), int'(bfly_mode1), int'(stage_idx1), busy1, done1);
    return pk(raw, rd_en2, int'(rd_addr_a2), int'(rd_addr_b2), int'(tw_addr2), wr_en2,
              int'(wr_addr_a2), int'(wr_addr_b2), int'(bfly_mode2), int'(stage_idx2), busy2, done2);
  endfunction

  // Butterfly k of stage s pairs element j of group g with its partner half away.
  function automatic void bf_addr(input int lg, input int s, input int k,
                                  output int a, output int b, output int tw);
    int half, g, j;
    half = 1 << s;
    g    = k / half;
    j    = k % half;
    a    = g * 2 * half + j;
    b    = a + half;
    tw   = j * ((1 << (lg - 1)) / half);
  endfunction

  task automatic drive(input int sel, input bit s, input bit ab, input logic [19:0] cfg);
    if (sel == 0) begin start1 = s; abort1 = ab; cfg1 = cfg[2*L1-1:0]; end
    else          begin start2 = s; abort2 = ab; cfg2 = cfg[2*L2-1:0]; end
  endtask

  task automatic run_fft(input int sel, input logic [19:0] cfg, input int abort_at,
                         input int busy_start_at, input bit start_on_done,
                         input bit scramble, input int reset_at);
    int lg, lat, n2, p, d, n_rd, n_dn, e_rd, e_dn;
    logic [63:0] o;
    lg  = (sel == 0) ? L1 : L2;
    lat = (sel == 0) ? R1 : R2;
    n2  = 1 << (lg - 1);
    p   = n2 + lat;
    d   = lg * p + 1;
    n_rd = 0; n_dn = 0; e_rd = 0; e_dn = 0;
    drive(sel, 1'b1, 1'b0, cfg);
    @(posedge clk); #1;
    for (int c = 1; c <= d + 3; c++) begin
      bit live, rd, wr, bs, dn, st_now;
      int a, b, tw, wa, wb, wtw, t, st;
      a = 0; b = 0; tw = 0; wa = 0; wb = 0; wtw = 0;
      live = (c <= abort_at);
      rd = live && (c <= lg * p) && (((c - 1) % p) < n2);
      if (rd) bf_addr(lg, (c - 1) / p, (c - 1) % p, a, b, tw);
      t  = c - lat;
      wr = live && (t >= 1) && (t <= lg * p) && (((t - 1) % p) < n2);
      if (wr) begin
        bf_addr(lg, (t - 1) / p, (t - 1) % p, wa, wb, wtw);
        cur_mode[sel] = int'((cfg >> (2 * ((t - 1) / p))) & 20'd3);
      end
      bs = live && (c <= d);
      dn = live && (c == d);
      st = !bs ? 0 : ((c == d) ? lg - 1 : (c - 1) / p);
      e_rd += int'(rd);
      e_dn += int'(dn);
      o = obs(sel, 1'b0);
      n_rd += int'(o[59]);
      n_dn += int'(o[0]);
      check($sformatf("dut%0d_c%0d", sel, c), o,
            pk(1'b0, rd, a, b, tw, wr, wa, wb, cur_mode[sel], st, bs, dn));
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("dut%0d_async_rst", sel), obs(sel, 1'b1), 64'd0);
        drive(sel, 1'b0, 1'b0, cfg);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cur_mode[0] = 0;
        cur_mode[1] = 0;
        return;
      end
      st_now = ((c == busy_start_at) && (c <= abort_at) && (c <= d)) ||
               (start_on_done && (c == d) && (abort_at >= d));
      drive(sel, st_now, c == abort_at, scramble ? 20'($urandom) : cfg);
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, 1'b0, cfg);
    check($sformatf("dut%0d_n_rd", sel), 64'(n_rd), 64'(e_rd));
    check($sformatf("dut%0d_n_done", sel), 64'(n_dn), 64'(e_dn));
  endtask

  initial begin
    int ab;
    start1 = 1'b0; abort1 = 1'b0; cfg1 = '0;
    start2 = 1'b0; abort2 = 1'b0; cfg2 = '0;
    cur_mode[0] = 0;
    cur_mode[1] = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("dut0_reset", obs(0, 1'b1), 64'd0);
    check("dut1_reset", obs(1, 1'b1), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode alignment, start during busy, start coinciding with done.
    run_fft(0, 20'b11_10_01_00_11, 1000, 10, 1'b1, 1'b1, 1000);
    // Abort at stage 1, k = 7.
    run_fft(0, 20'($urandom), 25, 20, 1'b0, 1'b0, 1000);
    // Abort and start together while idle: abort wins.
    drive(0, 1'b1, 1'b1, 20'($urandom));
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 20'd0);
    check("abort_start_idle", obs(0, 1'b0),
          pk(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, cur_mode[0], 0, 1'b0, 1'b0));
    @(posedge clk); #1;
    check("abort_start_idle2", obs(0, 1'b0),
          pk(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0, cur_mode[0], 0, 1'b0, 1'b0));
    // Asynchronous reset in the middle of stage 2, then an immediate restart.
    run_fft(0, 20'($urandom), 1000, 1000, 1'b0, 1'b0, 40);
    run_fft(0, 20'($urandom), 1000, int'($urandom_range(85, 2)), 1'b0, 1'b1, 1000);
    for (int r = 0; r < 4; r++) begin
      ab = ($urandom_range(1, 0) == 1) ? int'($urandom_range(85, 1)) : 1000;
      run_fft(0, 20'($urandom), ab, int'($urandom_range(85, 2)), 1'b1, 1'b1, 1000);
    end

    // Small transform with a three-cycle read latency.
    run_fft(1, 20'($urandom), 1000, 5, 1'b1, 1'b1, 1000);
    run_fft(1, 20'($urandom), 12, 1000, 1'b0, 1'b0, 1000);
    for (int r = 0; r < 3; r++) begin
      ab = ($urandom_range(1, 0) == 1) ? int'($urandom_range(21, 1)) : 1000;
      run_fft(1, 20'($urandom), ab, int'($urandom_range(21, 2)), 1'b1, 1'b1, 1000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
